// File: rtl/tick_scheduler.sv
`timescale 1ns/1ps
// tick_scheduler: IDLE/RUN/PAUSE FSM gating two programmable tick channels (CONT, RU) as clock enables.
// Latency: ticks are registered, high one cycle after the wrap edge; no backpressure, commands act on the next edge.
module tick_scheduler #(
  parameter int unsigned W            = 25,
  parameter int unsigned PER_CONT_DEF = 65536,
  parameter int unsigned PER_RU_DEF   = 16777216
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  input  logic         cfg_we,
  input  logic         cfg_sel,
  input  logic [W-1:0] cfg_data,
  output logic         tick_cont,
  output logic         tick_ru,
  output logic [1:0]   scan_sel,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } st_t;

  localparam logic [W-1:0] CONT_DEF = W'(PER_CONT_DEF);
  localparam logic [W-1:0] RU_DEF   = W'(PER_RU_DEF);
  localparam logic [W-1:0] ONE      = W'(1);

  st_t          cur_st;
  st_t          nxt_st;
  logic [W-1:0] per_q [2];
  logic [W-1:0] shd_q [2];
  logic [W-1:0] cnt_q [2];
  logic [1:0]   tick_q;
  logic [1:0]   wrap;
  logic [1:0]   load;
  logic         cnt_en;
  logic         clr;

  // Priority stop > pause > start; unlisted encodings fall back to IDLE.
  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      ST_IDLE: begin
        if (stop)       nxt_st = ST_IDLE;
        else if (start) nxt_st = ST_RUN;
      end
      ST_RUN: begin
        if (stop)       nxt_st = ST_IDLE;
        else if (pause) nxt_st = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop)       nxt_st = ST_IDLE;
        else if (start) nxt_st = ST_RUN;
      end
      default:          nxt_st = ST_IDLE;
    endcase
  end

  // The edge that leaves RUN does not count, so a resume continues exactly where pause left off.
  always_comb begin
    cnt_en = (cur_st == ST_RUN) && (nxt_st == ST_RUN);
    clr    = (nxt_st == ST_IDLE);
    wrap   = '0;
    load   = '0;
    for (int i = 0; i < 2; i++) begin
      wrap[i] = (cnt_q[i] == (per_q[i] - ONE));
      load[i] = (cnt_en && wrap[i]) || (cur_st == ST_IDLE) ||
                ((cur_st == ST_PAUSE) && stop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_st   <= ST_IDLE;
      tick_q   <= '0;
      scan_sel <= '0;
      per_q[0] <= CONT_DEF;
      per_q[1] <= RU_DEF;
      shd_q[0] <= CONT_DEF;
      shd_q[1] <= RU_DEF;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      cur_st <= nxt_st;
      for (int i = 0; i < 2; i++) begin
        // A write on a wrap edge lands in the shadow only; the active period takes the old shadow.
        if (cfg_we && (cfg_sel == 1'(i)))
          shd_q[i] <= (cfg_data == '0) ? ONE : cfg_data;
        if (load[i])
          per_q[i] <= shd_q[i];
        if (clr)
          cnt_q[i] <= '0;
        else if (cnt_en)
          cnt_q[i] <= wrap[i] ? '0 : cnt_q[i] + ONE;
        tick_q[i] <= cnt_en && wrap[i];
      end
      if (clr)
        scan_sel <= '0;
      else if (cnt_en && wrap[0])
        scan_sel <= scan_sel + 2'd1;
    end
  end

  assign tick_cont = tick_q[0];
  assign tick_ru   = tick_q[1];
  assign state     = cur_st;

endmodule

// File: tb/tb_tick_scheduler.sv
`timescale 1ns/1ps
// Directed bench for tick_scheduler: a command/expectation table plus hand sequences
// for period reload, zero-period write and reset-to-default.
module tb_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, pause, stop, cfg_we, cfg_sel;
  logic [24:0] cfg_data;
  logic        tick_cont, tick_ru;
  logic [1:0]  scan_sel, state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .tick_cont(tick_cont),
    .tick_ru  (tick_ru),
    .scan_sel (scan_sel),
    .state    (state)
  );

  typedef struct {
    logic        st, pa, sp, we, sel;
    logic [24:0] d;
    logic        etc, etr;
    logic [1:0]  esc, est;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic st, input logic pa, input logic sp, input logic we,
                     input logic sel, input int d, input logic etc, input logic etr,
                     input int esc, input int est);
    vec_t v;
    v.st = st; v.pa = pa; v.sp = sp; v.we = we; v.sel = sel; v.d = 25'(d);
    v.etc = etc; v.etr = etr; v.esc = 2'(esc); v.est = 2'(est);
    tbl.push_back(v);
  endtask

  task automatic drive(input logic st, input logic pa, input logic sp, input logic we,
                       input logic sel, input int d);
    start = st; pause = pa; stop = sp; cfg_we = we; cfg_sel = sel; cfg_data = 25'(d);
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic etc, input logic etr,
                         input logic [1:0] esc, input logic [1:0] est);
    chk({tag, "_tick_cont"}, 32'(tick_cont), 32'(etc));
    chk({tag, "_tick_ru"},   32'(tick_ru),   32'(etr));
    chk({tag, "_scan_sel"},  32'(scan_sel),  32'(esc));
    chk({tag, "_state"},     32'(state),     32'(est));
  endtask

  initial begin
    int first;
    int ru_cnt;
    logic exp_t;

    // inputs: start pause stop we sel data | expected: tick_cont tick_ru scan_sel state
    row(0,0,0,1,0,4, 0,0,0,0);                      // CONT = 4 in IDLE
    row(1,0,0,0,0,0, 0,0,0,1);                      // start
    row(0,0,0,0,0,0, 0,0,0,1); row(0,0,0,0,0,0, 0,0,0,1); row(0,0,0,0,0,0, 0,0,0,1);
    row(0,0,0,0,0,0, 1,0,1,1);                      // RUN edge 4
    row(0,0,0,0,0,0, 0,0,1,1); row(0,0,0,0,0,0, 0,0,1,1); row(0,0,0,0,0,0, 0,0,1,1);
    row(0,0,0,0,0,0, 1,0,2,1);                      // edge 8
    row(0,0,0,0,0,0, 0,0,2,1); row(0,0,0,0,0,0, 0,0,2,1); row(0,0,0,0,0,0, 0,0,2,1);
    row(0,0,0,0,0,0, 1,0,3,1);                      // edge 12
    row(0,0,0,0,0,0, 0,0,3,1); row(0,0,0,0,0,0, 0,0,3,1); // c = 2
    row(0,1,0,0,0,0, 0,0,3,2);                      // pause, 5 cycles
    row(0,0,0,0,0,0, 0,0,3,2); row(0,0,0,0,0,0, 0,0,3,2);
    row(0,0,0,0,0,0, 0,0,3,2); row(0,0,0,0,0,0, 0,0,3,2);
    row(1,0,0,0,0,0, 0,0,3,1);                      // resume
    row(0,0,0,0,0,0, 0,0,3,1);
    row(0,0,0,0,0,0, 1,0,0,1);                      // 2 RUN edges after resume
    row(1,0,0,0,0,0, 0,0,0,1);                      // start in RUN ignored
    row(0,0,0,0,0,0, 0,0,0,1); row(0,0,0,0,0,0, 0,0,0,1);
    row(0,0,0,0,0,0, 1,0,1,1);
    row(0,0,0,0,0,0, 0,0,1,1);
    row(1,1,1,0,0,0, 0,0,0,0);                      // all commands: stop wins
    row(1,0,0,0,0,0, 0,0,0,1);
    row(0,0,0,0,0,0, 0,0,0,1); row(0,0,0,0,0,0, 0,0,0,1); row(0,0,0,0,0,0, 0,0,0,1);
    row(0,0,0,0,0,0, 1,0,1,1);                      // counter had been cleared
    row(1,1,0,0,0,0, 0,0,1,2);                      // pause beats start
    row(1,0,1,0,0,0, 0,0,0,0);                      // stop beats start in PAUSE
    row(0,1,0,0,0,0, 0,0,0,0);                      // pause in IDLE ignored
    row(1,0,1,0,0,0, 0,0,0,0);                      // stop beats start in IDLE
    row(0,0,0,1,1,0, 0,0,0,0);                      // RU = 0 -> stored as 1
    row(1,0,0,0,0,0, 0,0,0,1);
    row(0,0,0,0,0,0, 0,1,0,1); row(0,0,0,0,0,0, 0,1,0,1); row(0,0,0,0,0,0, 0,1,0,1);
    row(0,0,0,0,0,0, 1,1,1,1);
    row(0,0,1,0,0,0, 0,0,0,0);

    idle_in();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk_all("reset", 0, 0, 2'd0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].pa, tbl[i].sp, tbl[i].we, tbl[i].sel, int'(tbl[i].d));
      step();
      idle_in();
      chk_all($sformatf("row%0d", i), tbl[i].etc, tbl[i].etr, tbl[i].esc, tbl[i].est);
    end

    // Mid-period reload: 8 completes, then 3; a write on a wrap edge waits one more wrap.
    drive(0, 0, 0, 1, 0, 8); step();
    drive(1, 0, 0, 0, 0, 0); step();
    idle_in();
    for (int e = 1; e <= 30; e++) begin
      if (e == 4)  drive(0, 0, 0, 1, 0, 3);
      if (e == 17) drive(0, 0, 0, 1, 0, 5);
      step();
      idle_in();
      exp_t = (e == 8) || (e == 11) || (e == 14) || (e == 17) || (e == 20) ||
              (e == 25) || (e == 30);
      chk($sformatf("reload_e%0d_tick_cont", e), 32'(tick_cont), 32'(exp_t));
    end

    // Reset mid-period with custom periods and coincident commands/writes.
    drive(0, 0, 1, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0, 4); step();
    drive(0, 0, 0, 1, 1, 2); step();
    drive(1, 0, 0, 0, 0, 0); step();
    idle_in();
    step(); step(); step();
    reset = 1'b1;
    drive(1, 0, 0, 1, 0, 4);
    step();
    reset = 1'b0;
    idle_in();
    chk_all("midreset", 0, 0, 2'd0, 2'd0);

    drive(1, 0, 0, 0, 0, 0); step();
    idle_in();
    first  = 0;
    ru_cnt = 0;
    for (int e = 1; e <= 70000; e++) begin
      step();
      if (tick_ru) ru_cnt++;
      if (tick_cont) begin
        first = e;
        break;
      end
    end
    chk("default_cont_first_tick_edge", 32'(first), 32'd65536);
    chk("default_ru_no_tick", 32'(ru_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
